bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial "1001" sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `x_out`. A one-entry holding register lets back-to-back words stream with no idle bit between them. When no word is in flight, `x_out` drives a fixed idle level, so the downstream detector always sees a defined bit every cycle.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is ≥ 2.
- `MSB_FIRST`, default 1: 1 shifts out bit WIDTH-1 first; 0 shifts out bit 0 first.
- `IDLE_BIT`, default 1'b0: level driven on `x_out` while no word is in flight.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high.
- `data_in`  in  WIDTH: word to serialize.
- `data_valid`  in  1: `data_in` is valid.
- `data_ready`  out  1: block can accept a word this cycle.
- `x_out`  out  1: serial bit stream feeding the detector's `x`.
- `busy`  out  1: a word is being shifted (`x_out` carries data).
- `word_done`  out  1: high during the cycle `x_out` carries a word's last bit.

## Operation
- Transfer occurs at a rising edge when `data_valid && data_ready`.
- `data_ready` = `!hold_full && !reset`. It is combinational from registered state and never depends on `data_valid`.
- State machine (`SHIFT_IDLE`, `SHIFT_ACTIVE`) with bit counter `cnt` of width $clog2(WIDTH) and shift register `sr`.
- Load point: an edge where the state is `SHIFT_IDLE`, or `SHIFT_ACTIVE` with `cnt == WIDTH-1`. At a load point, in priority order:
  - If `hold_full`: `sr` ← hold, hold empties, `cnt` ← 0, state = `SHIFT_ACTIVE`.
  - Else if a transfer occurs: `sr` ← `data_in` directly (bypass), `cnt` ← 0, state = `SHIFT_ACTIVE`.
  - Else: state = `SHIFT_IDLE`.
- Not a load point, state `SHIFT_ACTIVE`: `sr` shifts by one toward the output end and `cnt` increments. A transfer here writes the holding register.
- Simultaneous events:
  - Hold empties at a load point while `data_valid` is high: no transfer, because `data_ready` was 0. `data_ready` rises the cycle after.
  - Hold empty, load point, transfer occurs: the word bypasses the hold; hold stays empty.
- Outputs:
  - `x_out` = `sr[WIDTH-1]` if `MSB_FIRST`, else `sr[0]`, when `busy`; otherwise `IDLE_BIT`.
  - `busy` = (state == `SHIFT_ACTIVE`).
  - `word_done` = `busy && cnt == WIDTH-1`.
- Data-dependent framing is not added. Patterns spanning word boundaries, or spanning idle bits, reach the detector unaltered.

## Timing
- Reset values, asserted asynchronously: state `SHIFT_IDLE`, `cnt` = 0, `sr` = 0, hold empty.
- Output values during and after reset: `x_out` = `IDLE_BIT`, `busy` = 0, `word_done` = 0. `data_ready` = 0 while `reset` is high and 1 on the first cycle after release.
- Latency: a word accepted at edge k into an idle block puts its first bit on `x_out` in cycle k+1 and its last bit in cycle k+WIDTH, with `word_done` high in that last cycle.
- Throughput: with `data_valid` held high continuously, `x_out` carries one data bit every cycle with no gaps.
- Reset mid-word: the in-flight word and the held word are discarded, and `x_out` returns to `IDLE_BIT` immediately (asynchronously).
- `data_in` is sampled only at the transfer edge. The upstream source may change it freely afterwards.

## Structure
- Shared package `bit_serializer_pkg`:
  - shifter state enum `SHIFT_IDLE` / `SHIFT_ACTIVE`.
  - localparam helper for counter width, $clog2(WIDTH).
- Sub-module `bit_serializer_hold`: a one-entry holding register with full flag, write-enable, read-enable, and `data_ready` generation.
- Top level contains the FSM, counter, shift register and output mux.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1, 8'h90 accepted at edge 0:
  - `x_out` = 1,0,0,1,0,0,0,0 in cycles 1–8.
  - `word_done` high only in cycle 8.
  - Cycle 9: `busy` = 0, `x_out` = 0.
  - Connected detector raises z in cycle 5.
- Back-to-back words 8'hA5 then 8'h3C, `data_valid` held high:
  - 16 contiguous data bits 1010010100111100 in cycles 1–16.
  - `data_ready` low from after the second accept until the hold drains.
  - No idle bit between the words.
- LSB-first, MSB_FIRST=0, 8'h01: `x_out` = 1,0,0,0,0,0,0,0.
- Back-pressure with the hold full and the shifter mid-word:
  - `data_valid` high with 8'hFF is ignored while `data_ready` = 0.
  - 8'hFF is accepted the cycle after the hold drains.
  - It is emitted immediately after the held word.
- Reset mid-word:
  - Setup: assert `reset` after 3 bits of 8'hF0, with 8'h0F held.
  - Expected: `x_out` = 0 and `busy` = 0 at once, `data_ready` = 0 during reset.
  - After release, 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1 with no leftover bits.
- IDLE_BIT = 1, no input: `x_out` = 1 every cycle and `busy` = 0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: shifter state encoding and
// the bit-counter width helper.
package bit_serializer_pkg;

    // Shifter state. Encoded as plain constants so existing code that
    // compares raw state bits keeps working.
    typedef logic [0:0] shift_state_t;

    localparam shift_state_t SHIFT_IDLE   = 1'b0;
    localparam shift_state_t SHIFT_ACTIVE = 1'b1;

    // Width of the bit counter for a given word width. Never narrower
    // than one bit, so the counter always exists.
    function automatic int cnt_width(input int width);
        if (width < 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register. It captures a word while the shifter is
// busy and hands it over at the next load point.
module bit_serializer_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             data_ready
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Capture on write, release on read. A write can only arrive while the
    // entry is empty and a read only while it is full, so the two never
    // collide in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (read_en) begin
                full_q <= 1'b0;
            end
            if (write_en) begin
                data_q <= write_data;
                full_q <= 1'b1;
            end
        end
    end

    // Ready depends only on registered state and reset, never on valid.
    always_comb begin
        read_data  = data_q;
        full       = full_q;
        data_ready = !full_q && !reset;
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the serial sequence detector. Words
// arrive over a valid/ready handshake and leave one bit per clock on
// x_out; a one-entry holding register keeps back-to-back words gapless.
//
// Handshake: a word transfers on a rising edge where data_valid and
// data_ready are both high. data_ready is derived from registered state
// only; the source must hold data_in stable while data_valid is high and
// not yet accepted, and may change it freely after the transfer edge.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int       WIDTH     = 8,
    parameter bit       MSB_FIRST = 1'b1,
    parameter logic     IDLE_BIT  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x_out,
    output logic             busy,
    output logic             word_done,
    output shift_state_t     debug_state
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    shift_state_t     state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_write;
    logic             hold_read;
    logic             transfer;
    logic             load_point;
    logic             last_bit;

    bit_serializer_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock      (clock),
        .reset      (reset),
        .write_en   (hold_write),
        .write_data (data_in),
        .read_en    (hold_read),
        .read_data  (hold_data),
        .full       (hold_full),
        .data_ready (data_ready)
    );

    // Decide where an accepted word goes. At a load point the hold has
    // priority; when the hold is empty the word bypasses straight into
    // the shifter. Between load points accepted words wait in the hold.
    always_comb begin
        last_bit   = (cnt == CNT_LAST);
        load_point = (state == SHIFT_IDLE) || last_bit;
        transfer   = data_valid && data_ready;
        hold_read  = load_point && hold_full;
        hold_write = transfer && !load_point;
    end

    // Shifter FSM, bit counter and shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SHIFT_IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else if (load_point) begin
            if (hold_full) begin
                sr    <= hold_data;
                cnt   <= '0;
                state <= SHIFT_ACTIVE;
            end else if (transfer) begin
                sr    <= data_in;
                cnt   <= '0;
                state <= SHIFT_ACTIVE;
            end else begin
                cnt   <= '0;
                state <= SHIFT_IDLE;
            end
        end else begin
            // Active and mid-word: move the next bit to the output end.
            if (MSB_FIRST) begin
                sr <= {sr[WIDTH-2:0], 1'b0};
            end else begin
                sr <= {1'b0, sr[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
        end
    end

    // Output mux. Because state resets asynchronously, x_out falls back to
    // the idle level the moment reset asserts.
    always_comb begin
        busy        = (state == SHIFT_ACTIVE);
        word_done   = busy && last_bit;
        debug_state = state;
        if (busy) begin
            x_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        end else begin
            x_out = IDLE_BIT;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: MSB-first main instance with a
// bit-level scoreboard, plus LSB-first and idle-high instances.
module tb_bit_serializer;
    import bit_serializer_pkg::*;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- DUT instances ----------------
    logic [7:0]   m_data;
    logic         m_valid = 1'b0;
    logic         m_ready, m_x, m_busy, m_done;
    shift_state_t m_state;

    logic [7:0]   l_data;
    logic         l_valid = 1'b0;
    logic         l_ready, l_x, l_busy, l_done;
    shift_state_t l_state;

    logic [7:0]   i_data = 8'h00;
    logic         i_valid = 1'b0;
    logic         i_ready, i_x, i_busy, i_done;
    shift_state_t i_state;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clock(clock), .reset(reset), .data_in(m_data), .data_valid(m_valid),
        .data_ready(m_ready), .x_out(m_x), .busy(m_busy), .word_done(m_done),
        .debug_state(m_state)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .data_in(l_data), .data_valid(l_valid),
        .data_ready(l_ready), .x_out(l_x), .busy(l_busy), .word_done(l_done),
        .debug_state(l_state)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_idle1 (
        .clock(clock), .reset(reset), .data_in(i_data), .data_valid(i_valid),
        .data_ready(i_ready), .x_out(i_x), .busy(i_busy), .word_done(i_done),
        .debug_state(i_state)
    );

    // ---------------- scoreboard ----------------
    // Entry = {last_bit_of_word, data_bit}.
    logic [1:0] exp_q[$];
    logic [1:0] lsb_q[$];

    // Monitor for the main instance: every busy cycle must carry the next
    // expected bit; every idle cycle must show the idle level.
    always @(negedge clock) begin
        logic [1:0] e;
        checks++;
        if (m_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_extra_bit: busy with x_out=%b but no bit expected", m_x);
            end else begin
                e = exp_q.pop_front();
                if (m_x !== e[0] || m_done !== e[1])
                begin
                    errors++;
                    $display("FAIL mon_bit: x_out=%b word_done=%b, expected x_out=%b word_done=%b at %0t",
                             m_x, m_done, e[0], e[1], $time);
                end
            end
        end else if (m_x !== 1'b0 || m_done !== 1'b0) begin
            errors++;
            $display("FAIL mon_idle: x_out=%b word_done=%b, expected 0/0 at %0t", m_x, m_done, $time);
        end
    end

    // ---------------- driver ----------------
    // Offers a word on the main instance and returns how many cycles
    // data_ready held it off. Entered and left at posedge+1.
    task automatic send_msb(input logic [7:0] w, output int waited);
        int cyc = 0;
        m_valid = 1'b1;
        m_data  = w;
        while (m_ready !== 1'b1 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        waited = cyc;
        if (cyc >= 100) begin
            checks++; errors++;
            $display("FAIL send_timeout: data_ready stayed %b for word %h", m_ready, w);
        end else begin
            @(posedge clock);
            for (int i = 7; i >= 0; i--) exp_q.push_back({(i == 0), w[i]});
        end
        #1;
        m_valid = 1'b0;
        m_data  = 8'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (m_x !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_ready !== 1'b0 ||
            m_state !== SHIFT_IDLE) begin
            errors++;
            $display("FAIL reset_hold: x=%b busy=%b done=%b ready=%b state=%b, expected 0/0/0/0/0",
                     m_x, m_busy, m_done, m_ready, m_state);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (m_ready !== 1'b1 || m_busy !== 1'b0 || m_x !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b x=%b, expected 1/0/0", m_ready, m_busy, m_x);
        end
        wait_cycles(1);
    endtask

    task automatic test_single();
        int w;
        send_msb(8'h90, w);
        @(negedge clock);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: busy=%b in cycle 1, expected 1", m_busy);
        end
        repeat (8) @(negedge clock);
        checks++;
        if (m_busy !== 1'b0 || m_x !== 1'b0) begin
            errors++;
            $display("FAIL single_end: busy=%b x=%b in cycle 9, expected 0/0", m_busy, m_x);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int w;
        send_msb(8'hA5, w);
        send_msb(8'h3C, w);
        checks++;
        if (m_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready: data_ready=%b after second accept, expected 0", m_ready);
        end
        for (int c = 2; c <= 16; c++) begin
            @(negedge clock);
            checks++;
            if (m_busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap: busy=%b in cycle %0d, expected 1", m_busy, c);
            end
        end
        @(negedge clock);
        checks++;
        if (m_busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b pending=%0d, expected 0/0", m_busy, exp_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure();
        int w;
        send_msb(8'hC3, w);
        send_msb(8'h5A, w);
        // Hold full, shifter mid-word: 8'hFF must wait for the hold to drain.
        send_msb(8'hFF, w);
        checks++;
        if (w != 7) begin
            errors++;
            $display("FAIL bp_wait: 8'hFF held off %0d cycles, expected 7", w);
        end
        wait_cycles(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d bits still pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        int w;
        send_msb(8'hF0, w);
        send_msb(8'h0F, w);
        @(negedge clock); @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        checks++;
        if (m_x !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: x=%b busy=%b ready=%b, expected 0/0/0", m_x, m_busy, m_ready);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: ready=%b busy=%b, expected 1/0", m_ready, m_busy);
        end
        send_msb(8'h81, w);
        repeat (9) @(negedge clock);
        checks++;
        if (exp_q.size() != 0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_clean: pending=%0d busy=%b, expected 0/0", exp_q.size(), m_busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_lsb_first();
        logic [1:0] e;
        logic [7:0] word = 8'h01;
        l_valid = 1'b1;
        l_data  = word;
        checks++;
        if (l_ready !== 1'b1) begin
            errors++;
            $display("FAIL lsb_ready: data_ready=%b, expected 1", l_ready);
        end
        @(posedge clock);
        for (int i = 0; i < 8; i++) lsb_q.push_back({(i == 7), word[i]});
        #1;
        l_valid = 1'b0;
        l_data  = 8'($urandom);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            e = lsb_q.pop_front();
            checks++;
            if (l_busy !== 1'b1 || l_x !== e[0] || l_done !== e[1]) begin
                errors++;
                $display("FAIL lsb_bit%0d: busy=%b x=%b done=%b, expected 1/%b/%b",
                         c, l_busy, l_x, l_done, e[0], e[1]);
            end
        end
        @(negedge clock);
        checks++;
        if (l_busy !== 1'b0 || l_x !== 1'b0) begin
            errors++;
            $display("FAIL lsb_end: busy=%b x=%b, expected 0/0", l_busy, l_x);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_idle_high();
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            checks++;
            if (i_x !== 1'b1 || i_busy !== 1'b0 || i_done !== 1'b0 || i_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_high: x=%b busy=%b done=%b ready=%b, expected 1/0/0/1",
                         i_x, i_busy, i_done, i_ready);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 12; n++) begin
            send_msb(8'($urandom), w);
            wait_cycles($urandom_range(0, 10));
        end
        wait_cycles(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d bits pending, expected 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_data = 8'h00;
        l_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_backpressure();
        test_reset_mid_word();
        test_idle_high();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
